traffic_phase_scheduler: RTL and testbench

- Demand-driven phase scheduler for a four-signal junction: main-1 (M1), main-2 (M2), main-turn (MT) and side (S).
- Latches vehicle requests for three phases and grants green round-robin, bounded by min/max green.
- Sequences yellow and all-red clearance between grants, driving the same 3-bit lamp encoding as the existing fixed-time controller.
- Rests in the main phase when there is no demand.
- Timing is counted in ticks of an external 1 Hz strobe.

---
 rtl/tlc_pkg.sv | 23 ++
 rtl/tlc_rr_pick.sv | 32 +++
 rtl/traffic_phase_scheduler.sv | 134 +++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared lamp encoding, phase/state types and the phase-to-green-lamp map
// for the junction phase scheduler.
package tlc_pkg;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  typedef enum logic [1:0] {MAIN = 2'd0, TURN = 2'd1, SIDE = 2'd2} phase_t;
  typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALL_RED = 2'd2} state_t;

  // Green mask bit order: [0]=M1 [1]=M2 [2]=MT [3]=S
  function automatic logic [3:0] phase_lamps(phase_t p);
    logic [3:0] m;
    case (p)
      TURN:    m = 4'b0101;
      SIDE:    m = 4'b1000;
      default: m = 4'b0011;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin picker: first pending phase after the current one, wrapping,
// never the current phase itself.
module tlc_rr_pick
  import tlc_pkg::*;
(
  input  logic [2:0] i_pending,
  input  phase_t     i_cur,
  output logic       o_valid,
  output phase_t     o_pick
);

  phase_t w_p1, w_p2;

  always_comb begin
    w_p1 = TURN;
    w_p2 = SIDE;
    case (i_cur)
      TURN:    begin w_p1 = SIDE; w_p2 = MAIN; end
      SIDE:    begin w_p1 = MAIN; w_p2 = TURN; end
      default: ;
    endcase
    o_valid = 1'b1;
    o_pick  = w_p1;
    if (i_pending[w_p1])      o_pick = w_p1;
    else if (i_pending[w_p2]) o_pick = w_p2;
    else begin
      o_valid = 1'b0;
      o_pick  = i_cur;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven GREEN/YELLOW/ALL_RED phase scheduler with registered lamps.
// Optional emergency preempt to MAIN is built when TLC_PREEMPT_EN is defined.
module traffic_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 15,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 5
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] req,
`ifdef TLC_PREEMPT_EN
  input  logic       preempt,
`endif
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [1:0] phase,
  output logic       grant
);

  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);

  state_t                r_state, w_state_nx;
  phase_t                r_phase, w_phase_nx;
  phase_t                r_next,  w_next_nx;
  logic [CNT_W-1:0]      r_timer, w_timer_nx;
  logic [2:0]            r_pending, w_pend_nx, w_ign;
  logic                  r_grant, w_enter_green;
  logic [3:0][2:0]       r_lamps, w_lamps_nx;
  logic [3:0]            w_ma, w_mb;
  logic                  w_pick_vld;
  phase_t                w_pick;

  tlc_rr_pick u_pick (
    .i_pending (r_pending),
    .i_cur     (r_phase),
    .o_valid   (w_pick_vld),
    .o_pick    (w_pick)
  );

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_next_nx  = r_next;
    case (r_state)
      GREEN:
        if (tick && w_pick_vld && r_timer >= MIN_C &&
            (!req[r_phase] || r_timer >= MAX_C)) begin
          w_state_nx = YELLOW;
          w_next_nx  = w_pick;
        end
      YELLOW:
        if (tick && r_timer == YEL_LAST)
          w_state_nx = (ALLRED_T == 0) ? GREEN : ALL_RED;
      ALL_RED:
        if (tick && r_timer == AR_LAST) w_state_nx = GREEN;
      default: w_state_nx = GREEN;
    endcase
`ifdef TLC_PREEMPT_EN
    // Preempt overrides the normal decision: head for MAIN, and hold MAIN once there.
    if (preempt) begin
      if (r_state == GREEN) begin
        if (r_phase != MAIN) begin
          w_state_nx = YELLOW;
          w_next_nx  = MAIN;
        end else begin
          w_state_nx = GREEN;
          w_next_nx  = r_next;
        end
      end else begin
        w_next_nx = MAIN;
      end
    end
`endif
    w_enter_green = (w_state_nx == GREEN) && (r_state != GREEN);
    if (w_enter_green) w_phase_nx = w_next_nx;

    if (w_state_nx != r_state)       w_timer_nx = '0;
    else if (tick && r_timer != '1)  w_timer_nx = r_timer + 1'b1;
    else                             w_timer_nx = r_timer;

    // Demand for the phase already showing green is meaningless and dropped.
    w_ign     = (r_state == GREEN) ? (3'b001 << r_phase) : 3'b000;
    w_pend_nx = r_pending | (req & ~w_ign);
    if (w_enter_green) w_pend_nx[w_phase_nx] = 1'b0;

    w_ma = phase_lamps(w_phase_nx);
    w_mb = phase_lamps(w_next_nx);
    for (int i = 0; i < 4; i++) begin
      case (w_state_nx)
        YELLOW:  w_lamps_nx[i] = (w_ma[i] && w_mb[i]) ? LAMP_G : (w_ma[i] ? LAMP_Y : LAMP_R);
        ALL_RED: w_lamps_nx[i] = (w_ma[i] && w_mb[i]) ? LAMP_G : LAMP_R;
        default: w_lamps_nx[i] = w_ma[i] ? LAMP_G : LAMP_R;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= GREEN;
      r_phase   <= MAIN;
      r_next    <= MAIN;
      r_timer   <= '0;
      r_pending <= 3'b000;
      r_grant   <= 1'b0;
      r_lamps   <= {LAMP_R, LAMP_R, LAMP_G, LAMP_G};
    end else begin
      r_state   <= w_state_nx;
      r_phase   <= w_phase_nx;
      r_next    <= w_next_nx;
      r_timer   <= w_timer_nx;
      r_pending <= w_pend_nx;
      r_grant   <= w_enter_green;
      r_lamps   <= w_lamps_nx;
    end
  end

  assign light_M1 = r_lamps[0];
  assign light_M2 = r_lamps[1];
  assign light_MT = r_lamps[2];
  assign light_S  = r_lamps[3];
  assign phase    = r_phase;
  assign grant    = r_grant;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: expected output snapshots (with the tick count at which
// they must appear) are queued ahead of stimulus; a monitor compares on change.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;

  typedef struct packed {
    logic [1:0] ph;
    logic [2:0] m1, m2, mt, s;
    logic       g;
  } out_t;

  typedef struct packed {
    int unsigned tk;
    out_t        o;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic [2:0] req = 3'b000;
  logic       preempt = 1'b0;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic [1:0] phase;
  logic       grant;

  int unsigned tick_no = 0;
  int          ntests = 0, nfail = 0;
  bit          mon_en = 1'b0;
  exp_t        exp_q[$];

  traffic_phase_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .req      (req),
`ifdef TLC_PREEMPT_EN
    .preempt  (preempt),
`endif
    .light_M1 (light_M1),
    .light_M2 (light_M2),
    .light_MT (light_MT),
    .light_S  (light_S),
    .phase    (phase),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  function automatic out_t cur_out();
    out_t o;
    o.ph = phase; o.m1 = light_M1; o.m2 = light_M2;
    o.mt = light_MT; o.s = light_S; o.g = grant;
    return o;
  endfunction

  task automatic push(input int unsigned tk, input logic [1:0] ph, input logic [2:0] m1,
                      input logic [2:0] m2, input logic [2:0] mt, input logic [2:0] s,
                      input logic g);
    exp_t e;
    e.tk = tk; e.o.ph = ph; e.o.m1 = m1; e.o.m2 = m2; e.o.mt = mt; e.o.s = s; e.o.g = g;
    exp_q.push_back(e);
  endtask

  // Green entry shows grant high for one cycle, then the same lamps with grant low.
  task automatic push_green(input int unsigned tk, input logic [1:0] ph, input logic [2:0] m1,
                            input logic [2:0] m2, input logic [2:0] mt, input logic [2:0] s);
    push(tk, ph, m1, m2, mt, s, 1'b1);
    push(tk, ph, m1, m2, mt, s, 1'b0);
  endtask

  task automatic do_tick();
    @(negedge clk); tick = 1'b1; tick_no++;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] r);
    @(negedge clk); req = r;
    @(negedge clk); req = 3'b000;
  endtask

  task automatic do_reset(input bit chg);
    @(negedge clk);
    if (chg) push(tick_no, 2'd0, G, G, R, R, 1'b0);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic check_main(input string name);
    out_t a;
    a = cur_out();
    ntests++;
    if (a !== {2'd0, G, G, R, R, 1'b0}) begin
      nfail++;
      $display("FAIL %s: got ph=%0d M1=%b M2=%b MT=%b S=%b g=%b, want ph=0 M1=001 M2=001 MT=100 S=100 g=0",
               name, a.ph, a.m1, a.m2, a.mt, a.s, a.g);
    end
  endtask

  initial begin : monitor
    out_t prev, cur;
    exp_t e;
    @(negedge clk); #1;
    prev = cur_out();
    forever begin
      @(negedge clk); #1;
      cur = cur_out();
      if (mon_en && cur != prev) begin
        ntests++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_change: got tk=%0d ph=%0d M1=%b M2=%b MT=%b S=%b g=%b, want no change",
                   tick_no, cur.ph, cur.m1, cur.m2, cur.mt, cur.s, cur.g);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.o || tick_no != e.tk) begin
            nfail++;
            $display("FAIL output_change: got tk=%0d ph=%0d M1=%b M2=%b MT=%b S=%b g=%b, want tk=%0d ph=%0d M1=%b M2=%b MT=%b S=%b g=%b",
                     tick_no, cur.ph, cur.m1, cur.m2, cur.mt, cur.s, cur.g,
                     e.tk, e.o.ph, e.o.m1, e.o.m2, e.o.mt, e.o.s, e.o.g);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin : stim
    int unsigned b, t;
    #1 rst = 1'b0;
    #20;
    check_main("reset_state");
    @(negedge clk); rst = 1'b1;
    mon_en = 1'b1;

    // Idle: rests in MAIN, no grant
    repeat (40) do_tick();

    // Side call from MAIN
    do_reset(1'b0);
    b = tick_no;
    push(b + 6, 2'd0, Y, Y, R, R, 1'b0);
    push(b + 8, 2'd0, R, R, R, R, 1'b0);
    push_green(b + 9, 2'd2, R, R, R, G);
    pulse(3'b100);
    repeat (10) do_tick();

    // MAIN demand held: green stretched to MAX_GREEN, then main re-served
    do_reset(1'b1);
    b = tick_no;
    push(b + 16, 2'd0, G, Y, R, R, 1'b0);
    push(b + 18, 2'd0, G, R, R, R, 1'b0);
    push_green(b + 19, 2'd1, G, R, G, R);
    push(b + 25, 2'd1, G, R, Y, R, 1'b0);
    push(b + 27, 2'd1, G, R, R, R, 1'b0);
    push_green(b + 28, 2'd0, G, G, R, R);
    @(negedge clk); req = 3'b011;
    @(negedge clk); req = 3'b001;
    repeat (16) do_tick();
    req = 3'b000;
    repeat (12) do_tick();

    // TURN and SIDE both pending: round-robin order
    do_reset(1'b0);
    b = tick_no;
    push(b + 6, 2'd0, G, Y, R, R, 1'b0);
    push(b + 8, 2'd0, G, R, R, R, 1'b0);
    push_green(b + 9, 2'd1, G, R, G, R);
    push(b + 15, 2'd1, Y, R, Y, R, 1'b0);
    push(b + 17, 2'd1, R, R, R, R, 1'b0);
    push_green(b + 18, 2'd2, R, R, R, G);
    pulse(3'b110);
    repeat (38) do_tick();
    t = tick_no + 1;
    push(t, 2'd2, R, R, R, Y, 1'b0);
    push(t + 2, 2'd2, R, R, R, R, 1'b0);
    push_green(t + 3, 2'd0, G, G, R, R);
    pulse(3'b001);
    repeat (4) do_tick();

    // Asynchronous reset mid-YELLOW clears pending
    do_reset(1'b0);
    b = tick_no;
    push(b + 6, 2'd0, Y, Y, R, R, 1'b0);
    pulse(3'b100);
    repeat (7) do_tick();
    @(negedge clk); #3;
    push(tick_no, 2'd0, G, G, R, R, 1'b0);
    rst = 1'b0;
    #1 check_main("async_reset_mid_yellow");
    @(negedge clk); rst = 1'b1;
    repeat (20) do_tick();

`ifdef TLC_PREEMPT_EN
    // Preempt from SIDE green back to MAIN, TURN served after release
    do_reset(1'b0);
    b = tick_no;
    push(b + 6, 2'd0, Y, Y, R, R, 1'b0);
    push(b + 8, 2'd0, R, R, R, R, 1'b0);
    push_green(b + 9, 2'd2, R, R, R, G);
    pulse(3'b100);
    repeat (10) do_tick();
    push(b + 10, 2'd2, R, R, R, Y, 1'b0);
    push(b + 12, 2'd2, R, R, R, R, 1'b0);
    push_green(b + 13, 2'd0, G, G, R, R);
    pulse(3'b010);
    @(negedge clk); preempt = 1'b1;
    repeat (23) do_tick();
    @(negedge clk); preempt = 1'b0;
    t = tick_no + 1;
    push(t, 2'd0, G, Y, R, R, 1'b0);
    push(t + 2, 2'd0, G, R, R, R, 1'b0);
    push_green(t + 3, 2'd1, G, R, G, R);
    repeat (4) do_tick();
`endif

    repeat (4) @(negedge clk);
    #2;
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      ntests++;
      nfail++;
      $display("FAIL missing_change: got no change, want tk=%0d ph=%0d M1=%b M2=%b MT=%b S=%b g=%b",
               e.tk, e.o.ph, e.o.m1, e.o.m2, e.o.mt, e.o.s, e.o.g);
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
